// File: rtl/nor_logic_unit_serial.sv
// -----------------------------------------------------------------------------
// nor_logic_unit_serial
//
// Bit-serial logic unit. A request latches two WIDTH-bit operands and a 3-bit
// function select. The unit then evaluates one bit per clock, LSB first. Each
// per-bit function is built only from 2-input NOR primitives.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled on the rising edge while IDLE or DONE
//   op     in   [2:0] function select, latched with start
//   a      in   [WIDTH-1:0] operand A, latched with start
//   b      in   [WIDTH-1:0] operand B, latched with start
//   busy   out  high while bits are being processed (RUN)
//   done   out  one-cycle pulse, s holds a new result (DONE)
//   s      out  [WIDTH-1:0] result register
//
// Handshake: start is a single-cycle request. It is accepted on a rising edge
// only when the unit is in IDLE or DONE; in RUN it is ignored and not queued.
// After acceptance, busy is high for exactly WIDTH cycles. done is then high
// for exactly one cycle, and s is updated on the edge that raises done. A start
// presented in that DONE cycle is accepted immediately, so one result is
// produced every WIDTH+1 cycles.
//
// op encoding (x = a[i], y = b[i]):
//   000 AND    001 OR     010 NAND   011 NOR
//   100 XOR    101 XNOR   110 NOT A  111 PASS A
// -----------------------------------------------------------------------------
module nor_logic_unit_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // NOR primitive and the per-bit function networks built from it
  // ---------------------------------------------------------------------------
  function automatic logic nor2(input logic x, input logic y);
    return ~(x | y);
  endfunction

  function automatic logic eval_bit(input logic [2:0] f, input logic x,
                                    input logic y);
    logic nx, ny, nxy, t, n2, n3, xn;
    nx  = nor2(x, x);
    ny  = nor2(y, y);
    nxy = nor2(x, y);
    t   = nor2(nx, ny);   // AND
    // XNOR: 4-NOR network. n2 = ~x & y, n3 = x & ~y, and xn = NOR of the two.
    n2  = nor2(x, nxy);
    n3  = nor2(y, nxy);
    xn  = nor2(n2, n3);
    case (f)
      3'b000:  eval_bit = t;
      3'b001:  eval_bit = nor2(nxy, nxy);
      3'b010:  eval_bit = nor2(t, t);
      3'b011:  eval_bit = nxy;
      3'b100:  eval_bit = nor2(xn, xn);  // fifth NOR inverts XNOR into XOR
      3'b101:  eval_bit = xn;
      3'b110:  eval_bit = nx;
      default: eval_bit = nor2(nx, nx);
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [2:0]       op_q,    op_d;
  // The operand registers shift right with the result, so the bit at index
  // cnt of the original operand always sits at position 0.
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] sh_q,    sh_d;
  logic [WIDTH-1:0] s_q,     s_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  logic             bit_res;
  logic [WIDTH-1:0] sh_next;

  // The result bit enters at the MSB. After WIDTH shifts, bit 0 of the result
  // reaches position 0.
  always_comb begin
    bit_res = eval_bit(op_q, a_q[0], b_q[0]);
    sh_next = sh_q >> 1;
    sh_next[WIDTH-1] = bit_res;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    s_d     = s_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          cnt_d   = '0;
          sh_d    = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        sh_d  = sh_next;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          s_d     = sh_next;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          busy_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      s_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;

endmodule

// File: tb/tb_nor_logic_unit_serial.sv
module tb_nor_logic_unit_serial;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [7:0] a = 8'd0, b = 8'd0;
  logic       busy, done;
  logic [7:0] s;

  // WIDTH=1 instance
  logic       start1 = 1'b0;
  logic [2:0] op1 = 3'd0;
  logic [0:0] a1 = 1'b0, b1 = 1'b0;
  logic       busy1, done1;
  logic [0:0] s1;

  nor_logic_unit_serial #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .s(s)
  );

  nor_logic_unit_serial #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .s(s1)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (WIDTH=8)
  // ---------------------------------------------------------------------------
  // Presents a request; the next rising edge (E0) samples it.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib,
                       input logic [2:0] iop);
    start = 1'b1;
    a = ia;
    b = ib;
    op = iop;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Called just after E0. Checks WIDTH busy cycles and then the done cycle,
  // and returns at the falling edge inside the DONE cycle.
  task automatic expect_result(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_nodone"}, 32'(done), 32'd0);
    end
    @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_s"}, 32'(s), 32'(e));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [7:0] sweep_exp [0:7];
  initial begin
    sweep_exp[0] = 8'hC0; sweep_exp[1] = 8'hFC;
    sweep_exp[2] = 8'h3F; sweep_exp[3] = 8'h03;
    sweep_exp[4] = 8'h3C; sweep_exp[5] = 8'hC3;
    sweep_exp[6] = 8'h0F; sweep_exp[7] = 8'hF0;

    // Reset, then idle three cycles
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_s", 32'(s), 32'h00);
    end
    check("rst_s1", 32'(s1), 32'd0);

    // AND, then OR..PASS A back-to-back, each started in the previous DONE
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(sweep_exp[k]);
      issue(8'hF0, 8'hCC, 3'(k));
      expect_result($sformatf("op%0d", k));
    end
    @(negedge clk);
    check("hold_done", 32'(done), 32'd0);
    check("hold_s", 32'(s), 32'hF0);
    repeat (2) @(negedge clk);
    check("hold_s2", 32'(s), 32'hF0);

    // Reset in the middle of RUN, between edges after E4
    issue(8'hFF, 8'h00, 3'b111);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_s", 32'(s), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_nodone", 32'(done), 32'd0);
      check("abort_nobusy", 32'(busy), 32'd0);
    end
    check("abort_s_after", 32'(s), 32'h00);

    // start re-pulsed during RUN is ignored
    issue(8'hFF, 8'h00, 3'b000);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 2) begin
        start = 1'b1;
        a = 8'hAA;
        op = 3'b001;
      end
      if (i == 3) start = 1'b0;
      check("ign_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    check("ign_done", 32'(done), 32'd1);
    check("ign_s", 32'(s), 32'h00);
    @(negedge clk);
    check("ign_noq_busy", 32'(busy), 32'd0);
    check("ign_noq_done", 32'(done), 32'd0);

    // WIDTH=1: XOR(1,1)=0 then AND(1,1)=1
    @(negedge clk);
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; op1 = 3'b100;
    @(posedge clk);
    #1 start1 = 1'b0;
    @(negedge clk);
    check("w1_busy", 32'(busy1), 32'd1);
    check("w1_nodone", 32'(done1), 32'd0);
    @(negedge clk);
    check("w1_done", 32'(done1), 32'd1);
    check("w1_idle", 32'(busy1), 32'd0);
    check("w1_xor", 32'(s1), 32'd0);
    start1 = 1'b1; op1 = 3'b000;
    @(posedge clk);
    #1 start1 = 1'b0;
    @(negedge clk);
    check("w1_busy2", 32'(busy1), 32'd1);
    @(negedge clk);
    check("w1_done2", 32'(done1), 32'd1);
    check("w1_and", 32'(s1), 32'd1);
    @(negedge clk);
    check("w1_end", 32'(done1), 32'd0);
    check("w1_hold", 32'(s1), 32'd1);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
